// File: rtl/counter_pkg.sv
// Shared digit type and per-mode digit limits for the bounce counter.
package counter_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DEC_MAX = 4'd9;
  localparam digit_t HEX_MAX = 4'd15;

  function automatic digit_t digit_max(input logic dec_hex);
    return dec_hex ? DEC_MAX : HEX_MAX;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One up/down count digit with carry/borrow out; clear beats load beats count.
module counter_digit
  import counter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   up,
  input  digit_t max,
  input  logic   clr,
  input  logic   ld,
  input  digit_t ld_val,
  output digit_t val,
  output logic   co
);

  digit_t val_q;
  digit_t val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (ld) begin
      // Loads above the mode limit saturate, which only bites in decimal mode.
      val_d = (ld_val > max) ? max : ld_val;
    end else if (en) begin
      if (up) begin
        val_d = (val_q >= max) ? '0 : val_q + 4'd1;
      end else begin
        val_d = (val_q == '0) ? max : val_q - 4'd1;
      end
    end
  end

  always_comb begin
    co = en && (up ? (val_q >= max) : (val_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/bounce_counter.sv
// Up/down hex/BCD display counter with prescaled step tick and an end-to-end bouncing LED.
//   dir | meaning
//   0   | led shifts toward the MSB on each step
//   1   | led shifts toward the LSB on each step
module bounce_counter
  import counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned LED_W    = 24,
  parameter int unsigned SLOW_DIV = 100_000_000,
  parameter int unsigned FAST_DIV = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_down,
  input  logic                  fast,
  input  logic                  dec_hex,
  input  logic                  hold,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic [LED_W-1:0]      led,
  output logic                  tick,
  output logic                  wrap
);

  localparam logic [31:0] SLOW_TERM = 32'(SLOW_DIV - 1);
  localparam logic [31:0] FAST_TERM = 32'(FAST_DIV - 1);

  logic [31:0]      pre_q;
  logic [31:0]      pre_d;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;
  logic             dir_q;
  logic             dir_d;
  logic             tick_q;
  logic             tick_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             dec_hex_q;

  logic [31:0]      term;
  logic             pre_hit;
  logic             mode_chg;
  logic             step;
  digit_t           max_val;
  logic [DIGITS:0]  carry;

  // A step is swallowed whenever a mode change or load claims the same cycle.
  always_comb begin
    term     = fast ? FAST_TERM : SLOW_TERM;
    pre_hit  = (pre_q >= term);
    mode_chg = dec_hex ^ dec_hex_q;
    step     = !hold && pre_hit && !mode_chg && !load;
    max_val  = digit_max(dec_hex);
  end

  always_comb begin
    pre_d = pre_q;
    if (!hold) begin
      pre_d = pre_hit ? 32'd0 : pre_q + 32'd1;
    end
  end

  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    if (step) begin
      if (led_q[LED_W-1]) begin
        dir_d = 1'b1;
      end else if (led_q[0]) begin
        dir_d = 1'b0;
      end
      led_d = dir_d ? (led_q >> 1) : (led_q << 1);
    end
  end

  always_comb begin
    tick_d = step;
    wrap_d = step && carry[DIGITS];
  end

  assign carry[0] = step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    counter_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (carry[i]),
      .up     (up_down),
      .max    (max_val),
      .clr    (mode_chg),
      .ld     (load),
      .ld_val (load_val[4*i +: 4]),
      .val    (digits[4*i +: 4]),
      .co     (carry[i+1])
    );
  end

  // dec_hex_q tracks the input during reset so leaving reset never looks like a mode change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      led_q     <= LED_W'(1);
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      dec_hex_q <= dec_hex;
    end else begin
      pre_q     <= pre_d;
      led_q     <= led_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      dec_hex_q <= dec_hex;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bounce_counter.sv
// Scoreboard bench for bounce_counter with DIGITS=2, LED_W=4, SLOW_DIV=10, FAST_DIV=2.
module tb_bounce_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_down = 1'b1;
  logic       fast = 1'b0;
  logic       dec_hex = 1'b0;
  logic       hold = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] digits;
  logic [3:0] led;
  logic       tick;
  logic       wrap;

  typedef struct {
    string      name;
    logic [7:0] dig;
    logic [3:0] led;
    logic       tick;
    logic       wrap;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic probe = 1'b0;
  int   cyc = 0;
  int   last_tick = 0;

  bounce_counter #(
    .DIGITS   (2),
    .LED_W    (4),
    .SLOW_DIV (10),
    .FAST_DIV (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_down  (up_down),
    .fast     (fast),
    .dec_hex  (dec_hex),
    .hold     (hold),
    .load     (load),
    .load_val (load_val),
    .digits   (digits),
    .led      (led),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per DUT tick or per stimulus probe.
  always @(negedge clk) begin : mon
    exp_t e;
    if (tick === 1'b1 || probe) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", {31'd0, tick}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_digits"}, {24'd0, digits}, {24'd0, e.dig});
        chk({e.name, "_led"},    {28'd0, led},    {28'd0, e.led});
        chk({e.name, "_tick"},   {31'd0, tick},   {31'd0, e.tick});
        chk({e.name, "_wrap"},   {31'd0, wrap},   {31'd0, e.wrap});
        if (tick === 1'b1 && e.gap != 0) begin
          chk({e.name, "_gap"}, 32'(cyc - last_tick), 32'(e.gap));
        end
      end
      if (tick === 1'b1) last_tick = cyc;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tick(input string name, input logic [7:0] dig, input logic [3:0] l,
                           input logic w, input int gap);
    exp_t e;
    e = '{name, dig, l, 1'b1, w, gap};
    exp_q.push_back(e);
  endtask

  task automatic probe_chk(input string name, input logic [7:0] dig, input logic [3:0] l);
    exp_t e;
    e = '{name, dig, l, 1'b0, 1'b0, 0};
    exp_q.push_back(e);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic wait_tick(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tick === 1'b1) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s_timeout: no tick within %0d cycles", name, budget);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then slow hex up-count; first tick exactly 10 edges after release.
    repeat (3) next();
    probe_chk("reset", 8'h00, 4'h1);
    rst_n = 1'b1;
    repeat (9) next();
    probe_chk("pre_tick", 8'h00, 4'h1);
    push_tick("up1", 8'h01, 4'h2, 1'b0, 0);
    push_tick("up2", 8'h02, 4'h4, 1'b0, 10);
    push_tick("up3", 8'h03, 4'h8, 1'b0, 10);
    push_tick("up4", 8'h04, 4'h4, 1'b0, 10);
    push_tick("up5", 8'h05, 4'h2, 1'b0, 10);
    for (int i = 0; i < 5; i++) wait_tick("up", 20);

    // Hex wrap upward.
    load = 1'b1;
    load_val = 8'hFE;
    next();
    load = 1'b0;
    push_tick("hex_ff", 8'hFF, 4'h1, 1'b0, 10);
    push_tick("hex_wrap", 8'h00, 4'h2, 1'b1, 10);
    wait_tick("hex", 20);
    wait_tick("hex", 20);
    next();
    probe_chk("wrap_drop", 8'h00, 4'h2);

    // Decimal mode change clears, then down-count wraps and borrows.
    next();
    load = 1'b1;
    load_val = 8'h37;
    next();
    load = 1'b0;
    dec_hex = 1'b1;
    up_down = 1'b0;
    probe_chk("hex_load", 8'h37, 4'h2);
    next();
    probe_chk("mode_clr", 8'h00, 4'h2);
    push_tick("dec_wrap", 8'h99, 4'h4, 1'b1, 10);
    push_tick("dec_98", 8'h98, 4'h8, 1'b0, 10);
    wait_tick("dec", 20);
    wait_tick("dec", 20);
    load = 1'b1;
    load_val = 8'h10;
    next();
    load = 1'b0;
    push_tick("borrow", 8'h09, 4'h4, 1'b0, 10);
    wait_tick("borrow", 20);

    // Switch to fast with pre=7: step on the next edge, then every 2 clocks.
    repeat (7) next();
    fast = 1'b1;
    push_tick("fast_sw", 8'h08, 4'h2, 1'b0, 8);
    push_tick("fast_07", 8'h07, 4'h1, 1'b0, 2);
    push_tick("fast_06", 8'h06, 4'h2, 1'b0, 2);
    push_tick("fast_05", 8'h05, 4'h4, 1'b0, 2);
    for (int i = 0; i < 4; i++) wait_tick("fast", 10);

    // Hold for 30 cycles; load still acts and saturates in decimal mode.
    hold = 1'b1;
    repeat (10) next();
    load = 1'b1;
    load_val = 8'h3C;
    next();
    load = 1'b0;
    probe_chk("hold_load", 8'h39, 4'h4);
    repeat (20) next();
    probe_chk("hold_end", 8'h39, 4'h4);
    hold = 1'b0;
    push_tick("after_hold", 8'h38, 4'h8, 1'b0, 0);
    wait_tick("after_hold", 10);

    // Back to slow; load on a step cycle drops the step.
    fast = 1'b0;
    push_tick("slow_37", 8'h37, 4'h4, 1'b0, 10);
    wait_tick("slow", 20);
    repeat (9) next();
    load = 1'b1;
    load_val = 8'h52;
    next();
    load = 1'b0;
    probe_chk("load_collide", 8'h52, 4'h4);
    push_tick("post_collide", 8'h51, 4'h2, 1'b0, 20);
    wait_tick("post_collide", 25);

    // Reset mid-count, then first tick again 10 edges after release.
    repeat (4) next();
    rst_n = 1'b0;
    next();
    probe_chk("mid_reset", 8'h00, 4'h1);
    rst_n = 1'b1;
    repeat (9) next();
    probe_chk("rst_pre_tick", 8'h00, 4'h1);
    push_tick("rst_wrap", 8'h99, 4'h2, 1'b1, 0);
    wait_tick("rst", 15);

    next();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
